addsub4_alu: RTL and testbench

- Registered adder/subtractor with status flags, parameterised width (default 4 bits).
- Computes A+B+C0 or A-B style results, selected by AS. Returns the result F plus carry-out C4, borrow/carry flag CF, zero flag ZF and signed-overflow flag OF.
- Serves as the arithmetic datapath slice of the small teaching CPU. Inputs are combinational; all outputs are registered on one clock.

---
 rtl/addsub4_alu.sv | 79 +++++++
 tb/tb_addsub4_alu.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/addsub4_alu.sv
// Registered adder/subtractor with carry, borrow, zero and signed-overflow flags.
// The core sum uses 4-bit carry-lookahead groups rippling into each other.
module addsub4_alu #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C0,
    input  logic             AS,
    output logic [WIDTH-1:0] F,
    output logic             C4,
    output logic             CF,
    output logic             ZF,
    output logic             OF
);

    localparam int NGROUPS = (WIDTH + 3) / 4;
    localparam int PWIDTH  = NGROUPS * 4;

    // Group carries from generate/propagate; every carry is a flat two-level term.
    function automatic logic [3:0] cla4_carries(
        input logic [3:0] g,
        input logic [3:0] p,
        input logic       cin
    );
        logic [3:0] c;
        c[0] = g[0] | (p[0] & cin);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        return c;
    endfunction

    logic [WIDTH-1:0]  bx_s;
    logic [PWIDTH-1:0] g_s;
    logic [PWIDTH-1:0] p_s;
    logic [PWIDTH:0]   carry_s;
    logic [WIDTH-1:0]  sum_s;
    logic              cout_s;
    logic              ovf_s;

    // Operand conditioning and carry-lookahead sum; padded bits stay 0 above the MSB.
    always_comb begin
        bx_s             = B ^ {WIDTH{AS}};
        g_s              = '0;
        p_s              = '0;
        g_s[WIDTH-1:0]   = A & bx_s;
        p_s[WIDTH-1:0]   = A ^ bx_s;
        carry_s          = '0;
        carry_s[0]       = C0;
        for (int k = 0; k < NGROUPS; k++) begin
            carry_s[4*k+1 +: 4] = cla4_carries(g_s[4*k +: 4], p_s[4*k +: 4], carry_s[4*k]);
        end
        sum_s  = p_s[WIDTH-1:0] ^ carry_s[WIDTH-1:0];
        cout_s = carry_s[WIDTH];
        ovf_s  = carry_s[WIDTH] ^ carry_s[WIDTH-1];
    end

    // Output registers; reset leaves a zero result so ZF tracks F at all times.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            F  <= '0;
            C4 <= 1'b0;
            CF <= 1'b0;
            ZF <= 1'b1;
            OF <= 1'b0;
        end else begin
            F  <= sum_s;
            C4 <= cout_s;
            CF <= cout_s ^ AS;
            ZF <= (sum_s == '0);
            OF <= ovf_s;
        end
    end

endmodule

// File: tb/tb_addsub4_alu.sv
// Scoreboard bench for addsub4_alu: expected results queued at drive time,
// popped and compared one clock later against an integer reference model.
module tb_addsub4_alu;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         C0;
    logic         AS;
    logic [W-1:0] F;
    logic         C4;
    logic         CF;
    logic         ZF;
    logic         OF;

    typedef struct packed {
        logic [W-1:0] f;
        logic         c4;
        logic         cf;
        logic         zf;
        logic         of;
    } res_t;

    res_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    addsub4_alu #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (A),
        .B    (B),
        .C0   (C0),
        .AS   (AS),
        .F    (F),
        .C4   (C4),
        .CF   (CF),
        .ZF   (ZF),
        .OF   (OF)
    );

    // Reference: plain integer arithmetic, unsigned for carry/borrow, signed for overflow.
    function automatic res_t model(input logic rst, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c0, input logic as);
        res_t r;
        int   ua, ub, sa, sb, ut, st, ci;
        if (!rst) begin
            r.f  = '0;
            r.c4 = 1'b0;
            r.cf = 1'b0;
            r.zf = 1'b1;
            r.of = 1'b0;
            return r;
        end
        ua = int'(a);
        ub = int'(b);
        ci = c0 ? 1 : 0;
        sa = a[W-1] ? ua - (1 << W) : ua;
        sb = b[W-1] ? ub - (1 << W) : ub;
        if (!as) begin
            ut   = ua + ub + ci;
            st   = sa + sb + ci;
            r.c4 = (ut >= (1 << W));
        end else begin
            ut   = ua - ub - (1 - ci);
            st   = sa - sb - (1 - ci);
            r.c4 = (ut >= 0);
        end
        r.f  = ut[W-1:0];
        r.cf = r.c4 ^ as;
        r.zf = (r.f == '0);
        r.of = (st < -(1 << (W-1))) || (st > (1 << (W-1)) - 1);
        return r;
    endfunction

    task automatic apply(input logic rst, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c0, input logic as, input string tag);
        res_t obs;
        res_t e;
        @(negedge clk);
        rst_n = rst;
        A     = a;
        B     = b;
        C0    = c0;
        AS    = as;
        exp_q.push_back(model(rst, a, b, c0, as));
        @(posedge clk);
        #1;
        obs = {F, C4, CF, ZF, OF};
        e   = exp_q.pop_front();
        vectors++;
        assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s: A=%b B=%b C0=%b AS=%b got F=%b C4=%b CF=%b ZF=%b OF=%b, expected F=%b C4=%b CF=%b ZF=%b OF=%b",
                   tag, a, b, c0, as, obs.f, obs.c4, obs.cf, obs.zf, obs.of,
                   e.f, e.c4, e.cf, e.zf, e.of);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        A     = '0;
        B     = '0;
        C0    = 1'b0;
        AS    = 1'b0;

        apply(1'b0, 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 1'b1, 1'b1, "reset0");
        apply(1'b0, 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)), 1'b1, 1'b0, "reset1");

        apply(1'b1, 4'b0000, 4'b1111, 1'b1, 1'b0, "add_wrap_a");
        apply(1'b1, 4'b0011, 4'b1100, 1'b1, 1'b0, "add_wrap_b");
        apply(1'b1, 4'b0000, 4'b0001, 1'b1, 1'b0, "small_add");
        apply(1'b1, 4'b1100, 4'b0001, 1'b1, 1'b1, "sub");
        apply(1'b1, 4'b1100, 4'b0101, 1'b0, 1'b1, "sub_borrow_in");
        apply(1'b1, 4'b0001, 4'b0011, 1'b1, 1'b1, "sub_borrow_out");
        apply(1'b1, 4'b0111, 4'b0001, 1'b0, 1'b0, "signed_ovf");
        apply(1'b1, 4'b1000, 4'b0001, 1'b1, 1'b1, "signed_ovf_sub");
        apply(1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, "full_scale");

        for (int i = 0; i < 40; i++) begin
            apply(1'b1, 4'($urandom_range(15, 0)), 4'($urandom_range(15, 0)),
                  1'($urandom_range(1, 0)), 1'(i % 2), "back_to_back");
        end

        apply(1'b0, 4'b1111, 4'b0001, 1'b1, 1'b0, "reset_midstream");
        apply(1'b1, 4'b0101, 4'b0010, 1'b0, 1'b0, "after_reset");

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    for (int s = 0; s < 2; s++) begin
                        apply(1'b1, 4'(a), 4'(b), 1'(c), 1'(s), "sweep");
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
